// File: rtl/mmio_data_responder_pkg.sv
// Shared types and constants for the MEM-stage data responder.
// Holds the access FSM states, the I/O page map and the STATUS bit layout.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] PIN_OFS    = 16'h0000;
    localparam logic [15:0] POUT_OFS   = 16'h0004;
    localparam logic [15:0] STATUS_OFS = 16'h0008;

    localparam int CHG_BIT = 0;
    localparam int ERR_BIT = 1;

    // Decoded attributes of one access, captured when the request is accepted.
    typedef struct packed {
        logic        is_io;
        logic        is_store;
        logic        err;
        logic        in_range;
        logic [15:0] ofs;
    } access_t;

    function automatic logic io_ofs_valid(input logic [15:0] ofs);
        return (ofs == PIN_OFS) || (ofs == POUT_OFS) || (ofs == STATUS_OFS);
    endfunction

endpackage

// File: rtl/mmio_data_responder_if.sv
// Data-bus bundle between the pipeline's EX/MEM register (master) and the responder (slave).
interface mmio_data_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        ready;
    logic        stall;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, ready, stall
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, ready, stall
    );
endinterface

// File: rtl/mmio_data_responder_port_in_sync.sv
// Two-flop synchronizer for the external PortIn pins, plus a previous-value
// register whose comparison yields a one-cycle change pulse.
module port_in_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_in,
    output logic [7:0] sync_o,
    output logic       chg_o
);

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] prev_q,  prev_d;

    // Next values of the synchronizer chain and history register.
    always_comb begin
        sync1_d = port_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
            prev_q  <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = sync2_q;
    assign chg_o  = (sync2_q != prev_q);

endmodule

// File: rtl/mmio_data_responder.sv
// MEM-stage data responder: serves loads/stores from a wait-stated word RAM or
// from a small I/O page (PIN, POUT, STATUS), holding the pipeline via stall.
module mmio_data_responder
    import mmio_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 128,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
    parameter logic [31:0] IO_BASE      = 32'hFFFF_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    mmio_data_responder_if.slave    bus,
    input  logic [7:0]              PortIn,
    output logic [31:0]             PortOut
);

    localparam int         IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [31:0] mem [MEMORY_DEPTH];

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    access_t          acc_q, acc_d, acc_live_s, acc_cur_s;
    logic [IDX_W-1:0] idx_q, idx_d, idx_cur_s;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      pout_q, pout_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;

    logic             req_s;
    logic [29:0]      ram_word_s;
    logic [31:0]      status_s;
    logic [31:0]      rd_val_s;
    logic             commit_s;
    logic             ram_we_s;
    logic [7:0]       pin_sync_s;
    logic             pin_chg_s;

    port_in_sync u_port_in_sync (
        .clk     (clk),
        .reset   (reset),
        .port_in (PortIn),
        .sync_o  (pin_sync_s),
        .chg_o   (pin_chg_s)
    );

    // Decode the live request; in IDLE it is used directly, afterwards the latched copy.
    always_comb begin
        req_s      = bus.MemRead | bus.MemWrite;
        ram_word_s = bus.Address[31:2] - RAM_BASE[31:2];
        acc_live_s          = '0;
        acc_live_s.is_io    = (bus.Address[31:16] == IO_BASE[31:16]);
        acc_live_s.is_store = bus.MemWrite;
        acc_live_s.in_range = ({2'b00, ram_word_s} < 32'(MEMORY_DEPTH));
        acc_live_s.ofs      = {bus.Address[15:2], 2'b00};
        acc_live_s.err      = (bus.Address[1:0] != 2'b00)
                            | (bus.MemRead & bus.MemWrite)
                            | (acc_live_s.is_io ? ~io_ofs_valid(acc_live_s.ofs)
                                                : ~acc_live_s.in_range);
        if (state_q == IDLE) begin
            acc_cur_s = acc_live_s;
            idx_cur_s = ram_word_s[IDX_W-1:0];
        end else begin
            acc_cur_s = acc_q;
            idx_cur_s = idx_q;
        end
    end

    // Load data selected from the I/O page or RAM; stores return zero.
    always_comb begin
        status_s          = 32'd0;
        status_s[CHG_BIT] = chg_q;
        status_s[ERR_BIT] = err_q;
        rd_val_s          = 32'd0;
        if (acc_cur_s.is_store) begin
            rd_val_s = 32'd0;
        end else if (acc_cur_s.is_io) begin
            case (acc_cur_s.ofs)
                PIN_OFS:    rd_val_s = {24'd0, pin_sync_s};
                POUT_OFS:   rd_val_s = pout_q;
                STATUS_OFS: rd_val_s = status_s;
                default:    rd_val_s = 32'd0;
            endcase
        end else if (acc_cur_s.in_range) begin
            rd_val_s = mem[idx_cur_s];
        end else begin
            rd_val_s = 32'd0;
        end
    end

    // Access FSM: next state, wait counter, ready pulse and registered load data.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        ready_d  = 1'b0;
        rdata_d  = 32'd0;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    acc_d = acc_live_s;
                    idx_d = ram_word_s[IDX_W-1:0];
                    if (acc_live_s.is_io || (WAIT_STATES == 0)) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        rdata_d = rd_val_s;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_M1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    rdata_d = rd_val_s;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                commit_s = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Store side effects at the edge closing DONE; a CHG event beats a W1C clear.
    always_comb begin
        pout_d   = pout_q;
        chg_d    = chg_q | pin_chg_s;
        err_d    = err_q;
        ram_we_s = commit_s & acc_q.is_store & ~acc_q.is_io & acc_q.in_range & ~reset;
        if (commit_s && acc_q.is_store && acc_q.is_io) begin
            if (acc_q.ofs == POUT_OFS) begin
                pout_d = bus.WriteData;
            end else if (acc_q.ofs == STATUS_OFS) begin
                chg_d = (chg_q & ~bus.WriteData[CHG_BIT]) | pin_chg_s;
                err_d = err_q & ~bus.WriteData[ERR_BIT];
            end else begin
                pout_d = pout_q;
            end
        end else begin
            pout_d = pout_q;
        end
        if (commit_s && acc_q.err) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // Control and I/O register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            acc_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            pout_q  <= 32'd0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            pout_q  <= pout_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    // Word RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem[idx_q] <= bus.WriteData;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.stall    = req_s & ~ready_q;
    assign PortOut      = pout_q;

endmodule

// File: tb/tb_mmio_data_responder.sv
// Directed bench: a vector table on a 1-wait-state instance plus hand-written
// sequences for PortIn/STATUS timing and for abort/reset on a 3-wait-state instance.
module tb_mmio_data_responder;

    logic        clk = 1'b0;
    logic        rst, rst_b;
    logic        rd, wr, sel;
    logic [31:0] addr, wdata;
    logic [7:0]  port_in, port_in_b;
    logic [31:0] pout_a, pout_b;

    int tests = 0;
    int fails = 0;

    mmio_data_responder_if bus_a ();
    mmio_data_responder_if bus_b ();

    assign bus_a.MemRead   = rd & ~sel;
    assign bus_a.MemWrite  = wr & ~sel;
    assign bus_a.Address   = addr;
    assign bus_a.WriteData = wdata;
    assign bus_b.MemRead   = rd & sel;
    assign bus_b.MemWrite  = wr & sel;
    assign bus_b.Address   = addr;
    assign bus_b.WriteData = wdata;

    mmio_data_responder #(.MEMORY_DEPTH(128), .WAIT_STATES(1),
                          .RAM_BASE(32'h1001_0000), .IO_BASE(32'hFFFF_0000)) u_dut_a (
        .clk(clk), .reset(rst), .bus(bus_a), .PortIn(port_in), .PortOut(pout_a));

    mmio_data_responder #(.MEMORY_DEPTH(128), .WAIT_STATES(3),
                          .RAM_BASE(32'h1001_0000), .IO_BASE(32'hFFFF_0000)) u_dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b), .PortIn(port_in_b), .PortOut(pout_b));

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt [25];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access from just after a rising edge; return latency, load data and bus sanity.
    task automatic access(input logic s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdat, output logic bus_ok);
        logic rdy, st;
        logic [31:0] rdv;
        sel = s; rd = r; wr = w; addr = a; wdata = d;
        lat = -1; rdat = 32'd0; bus_ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (lat < 0) begin
                @(negedge clk);
                rdy = s ? bus_b.ready    : bus_a.ready;
                st  = s ? bus_b.stall    : bus_a.stall;
                rdv = s ? bus_b.ReadData : bus_a.ReadData;
                if (rdy) begin
                    lat  = c;
                    rdat = rdv;
                    if (st) bus_ok = 1'b0;
                end else if (!st || (rdv != 32'd0)) begin
                    bus_ok = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic set_v(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int l, input logic [31:0] e);
        vt[i] = '{r, w, a, d, l, e};
    endtask

    // Access with checks on latency, data and stall/ReadData behaviour.
    task automatic acc_chk(input string name, input logic s, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int el, input logic [31:0] ed);
        int lat;
        logic [31:0] rdat;
        logic ok;
        access(s, r, w, a, d, lat, rdat, ok);
        check32({name, "_lat"}, 32'(lat), 32'(el));
        check32({name, "_rdata"}, rdat, ed);
        check32({name, "_bus"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1; rst_b = 1'b1;
        rd = 1'b0; wr = 1'b0; sel = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        port_in = 8'h00; port_in_b = 8'h00;

        set_v( 0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 2, 32'h0000_0000);
        set_v( 1, 1'b1, 1'b0, 32'h1001_0008, 32'h0000_0000, 2, 32'hDEAD_BEEF);
        set_v( 2, 1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_00A5, 1, 32'h0000_0000);
        set_v( 3, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0000, 1, 32'h0000_00A5);
        set_v( 4, 1'b0, 1'b1, 32'h1001_01FC, 32'h1234_5678, 2, 32'h0000_0000);
        set_v( 5, 1'b1, 1'b0, 32'h1001_01FC, 32'h0000_0000, 2, 32'h1234_5678);
        set_v( 6, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0000);
        set_v( 7, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 1, 32'h0000_0000);
        set_v( 8, 1'b1, 1'b0, 32'h1001_0201, 32'h0000_0000, 2, 32'h0000_0000);
        set_v( 9, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0002);
        set_v(10, 1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0003, 1, 32'h0000_0000);
        set_v(11, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0000);
        set_v(12, 1'b0, 1'b1, 32'hFFFF_000C, 32'h0000_0077, 1, 32'h0000_0000);
        set_v(13, 1'b1, 1'b0, 32'hFFFF_000C, 32'h0000_0000, 1, 32'h0000_0000);
        set_v(14, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0002);
        set_v(15, 1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0003, 1, 32'h0000_0000);
        set_v(16, 1'b1, 1'b1, 32'h1001_0010, 32'h1122_3344, 2, 32'h0000_0000);
        set_v(17, 1'b1, 1'b0, 32'h1001_0010, 32'h0000_0000, 2, 32'h1122_3344);
        set_v(18, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0002);
        set_v(19, 1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0003, 1, 32'h0000_0000);
        set_v(20, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0000, 1, 32'h0000_00A5);
        set_v(21, 1'b0, 1'b1, 32'hFFFF_0006, 32'h0000_005A, 1, 32'h0000_0000);
        set_v(22, 1'b1, 1'b0, 32'hFFFF_0004, 32'h0000_0000, 1, 32'h0000_005A);
        set_v(23, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0000_0000, 1, 32'h0000_0002);
        set_v(24, 1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0003, 1, 32'h0000_0000);

        tick();
        tick();
        check32("rst_ready",    {31'd0, bus_a.ready}, 32'd0);
        check32("rst_readdata", bus_a.ReadData,       32'd0);
        check32("rst_portout",  pout_a,               32'd0);
        rst = 1'b0; rst_b = 1'b0;
        tick();

        // Back-to-back table accesses on the 1-wait-state instance.
        for (int i = 0; i < 25; i++) begin
            acc_chk($sformatf("v%0d", i), 1'b0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata,
                    vt[i].lat, vt[i].rdata);
            if (i == 2) check32("portout_after_commit", pout_a, 32'h0000_00A5);
        end
        check32("portout_final", pout_a, 32'h0000_005A);

        // PortIn synchronizer latency and CHG behaviour.
        port_in = 8'h3C;
        tick();
        acc_chk("pin_cycle1", 1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1, 32'h0000_0000);
        acc_chk("chg_set",    1'b0, 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 1, 32'h0000_0001);
        acc_chk("pin_3c",     1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1, 32'h0000_003C);
        acc_chk("chg_clr_wr", 1'b0, 1'b0, 1'b1, 32'hFFFF_0008, 32'd1, 1, 32'h0000_0000);
        acc_chk("chg_clr",    1'b0, 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 1, 32'h0000_0000);
        port_in = 8'h5A;
        tick();
        acc_chk("chg_race_wr", 1'b0, 1'b0, 1'b1, 32'hFFFF_0008, 32'd1, 1, 32'h0000_0000);
        acc_chk("chg_race",    1'b0, 1'b1, 1'b0, 32'hFFFF_0008, 32'd0, 1, 32'h0000_0001);
        port_in = 8'hC3;
        tick();
        tick();
        acc_chk("pin_cycle2", 1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1, 32'h0000_00C3);

        // Three-wait-state instance: latency, abort and reset in WAIT.
        acc_chk("b_pout_wr", 1'b1, 1'b0, 1'b1, 32'hFFFF_0004, 32'h55,          1, 32'd0);
        acc_chk("b_st",      1'b1, 1'b0, 1'b1, 32'h1001_0020, 32'hCAFE_F00D,   4, 32'd0);
        acc_chk("b_ld",      1'b1, 1'b1, 1'b0, 32'h1001_0020, 32'd0,           4, 32'hCAFE_F00D);

        sel = 1'b1; wr = 1'b1; addr = 32'h1001_0020; wdata = 32'h0BAD_BEEF;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | bus_b.ready;
        end
        tick();
        wr = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus_b.ready;
        end
        check32("abort_no_ready", {31'd0, seen}, 32'd0);
        tick();
        acc_chk("abort_ram", 1'b1, 1'b1, 1'b0, 32'h1001_0020, 32'd0, 4, 32'hCAFE_F00D);

        sel = 1'b1; wr = 1'b1; addr = 32'h1001_0020; wdata = 32'h0000_0000;
        tick();
        tick();
        rst_b = 1'b1;
        #1;
        check32("midrst_ready",    {31'd0, bus_b.ready}, 32'd0);
        check32("midrst_readdata", bus_b.ReadData,       32'd0);
        check32("midrst_portout",  pout_b,               32'd0);
        wr = 1'b0;
        tick();
        rst_b = 1'b0;
        tick();
        acc_chk("midrst_ram", 1'b1, 1'b1, 1'b0, 32'h1001_0020, 32'd0, 4, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
